// File: rtl/wt_dcache_miss_arb_if.sv
// Bundle between the dcache read controllers, the miss arbiter and the memory-side miss path.
// The arbiter uses the slave modport; the controller/memory environment uses the master modport.
interface wt_dcache_miss_arb_if #(
  parameter int NumPorts = 3,
  parameter int PlenW    = 56,
  parameter int IdW      = 2
);
  logic [NumPorts-1:0]       miss_req_i;
  logic [NumPorts*PlenW-1:0] miss_paddr_i;
  logic [NumPorts-1:0]       miss_nc_i;
  logic [NumPorts*3-1:0]     miss_size_i;
  logic [NumPorts-1:0]       miss_ack_o;
  logic [NumPorts-1:0]       miss_replay_o;
  logic [NumPorts-1:0]       miss_rtrn_vld_o;

  logic                      mem_req_o;
  logic                      mem_gnt_i;
  logic [PlenW-1:0]          mem_paddr_o;
  logic                      mem_nc_o;
  logic [2:0]                mem_size_o;
  logic [IdW-1:0]            mem_id_o;
  logic                      mem_rtrn_vld_i;
  logic [IdW-1:0]            mem_rtrn_id_i;

  modport master (
    output miss_req_i, miss_paddr_i, miss_nc_i, miss_size_i,
    output mem_gnt_i, mem_rtrn_vld_i, mem_rtrn_id_i,
    input  miss_ack_o, miss_replay_o, miss_rtrn_vld_o,
    input  mem_req_o, mem_paddr_o, mem_nc_o, mem_size_o, mem_id_o
  );

  modport slave (
    input  miss_req_i, miss_paddr_i, miss_nc_i, miss_size_i,
    input  mem_gnt_i, mem_rtrn_vld_i, mem_rtrn_id_i,
    output miss_ack_o, miss_replay_o, miss_rtrn_vld_o,
    output mem_req_o, mem_paddr_o, mem_nc_o, mem_size_o, mem_id_o
  );
endinterface

// File: rtl/wt_dcache_miss_arb.sv
// Round-robin miss arbiter: one outstanding miss per port, replay on line collision.
// Optional perf counters are built when WT_DCACHE_MISS_ARB_PERF_EN is defined.
module wt_dcache_miss_arb #(
  parameter int NumPorts = 3,
  parameter int PlenW    = 56,
  parameter int IdW      = 2,
  parameter int ClOffW   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  wt_dcache_miss_arb_if.slave  bus,
  output logic [NumPorts-1:0]  pend_o,
  output logic [31:0]          perf_grant_o,
  output logic [31:0]          perf_replay_o
);
  localparam int LineW = PlenW - ClOffW;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                          state_q, state_d;
  logic [NumPorts-1:0]             valid_q, valid_d;
  logic [NumPorts-1:0][LineW-1:0]  line_q, line_d;
  logic [IdW-1:0]                  rr_q, rr_d;
  logic [PlenW-1:0]                paddr_q, paddr_d;
  logic                            nc_q, nc_d;
  logic [2:0]                      size_q, size_d;
  logic [IdW-1:0]                  id_q, id_d;

  logic [NumPorts-1:0][LineW-1:0]  req_line;
  logic [NumPorts-1:0]             hit, replay, elig, ack, rtrn;
  logic                            found;
  logic [IdW-1:0]                  win;
  logic                            rtrn_hit;

  // A pending port re-raising its request is neither acked nor replayed.
  always_comb begin
    hit = '0;
    for (int p = 0; p < NumPorts; p++) begin
      req_line[p] = bus.miss_paddr_i[p*PlenW+ClOffW +: LineW];
      for (int j = 0; j < NumPorts; j++) begin
        if (valid_q[j] && (line_q[j] == req_line[p])) hit[p] = 1'b1;
      end
    end
    replay = bus.miss_req_i & ~valid_q & hit;
    elig   = bus.miss_req_i & ~valid_q & ~hit;
  end

  always_comb begin : p_pick
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int off = 0; off < NumPorts; off++) begin
      idx = (int'(rr_q) + off) % NumPorts;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = IdW'(idx);
      end
    end
  end

  assign rtrn_hit = bus.mem_rtrn_vld_i && (int'(bus.mem_rtrn_id_i) < NumPorts) &&
                    valid_q[bus.mem_rtrn_id_i];

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    line_d  = line_q;
    rr_d    = rr_q;
    paddr_d = paddr_q;
    nc_d    = nc_q;
    size_d  = size_q;
    id_d    = id_q;
    ack     = '0;
    rtrn    = '0;

    if (rtrn_hit) begin
      rtrn[bus.mem_rtrn_id_i]    = 1'b1;
      valid_d[bus.mem_rtrn_id_i] = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          ack[win]     = 1'b1;
          valid_d[win] = 1'b1;
          line_d[win]  = req_line[win];
          paddr_d      = bus.miss_paddr_i[int'(win)*PlenW +: PlenW];
          nc_d         = bus.miss_nc_i[win];
          size_d       = bus.miss_size_i[int'(win)*3 +: 3];
          id_d         = win;
          rr_d         = (int'(win) == NumPorts-1) ? '0 : win + 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      line_q  <= '0;
      rr_q    <= '0;
      paddr_q <= '0;
      nc_q    <= 1'b0;
      size_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      line_q  <= line_d;
      rr_q    <= rr_d;
      paddr_q <= paddr_d;
      nc_q    <= nc_d;
      size_q  <= size_d;
      id_q    <= id_d;
    end
  end

  assign bus.miss_ack_o      = ack;
  assign bus.miss_replay_o   = replay;
  assign bus.miss_rtrn_vld_o = rtrn;
  assign bus.mem_req_o       = (state_q == ISSUE);
  assign bus.mem_paddr_o     = paddr_q;
  assign bus.mem_nc_o        = nc_q;
  assign bus.mem_size_o      = size_q;
  assign bus.mem_id_o        = id_q;
  assign pend_o              = valid_q;

`ifdef WT_DCACHE_MISS_ARB_PERF_EN
  logic [31:0] grant_cnt_q, replay_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_cnt_q  <= '0;
      replay_cnt_q <= '0;
    end else begin
      if ((|ack) && (grant_cnt_q != 32'hFFFF_FFFF)) grant_cnt_q <= grant_cnt_q + 32'd1;
      if ((|replay) && (replay_cnt_q != 32'hFFFF_FFFF)) replay_cnt_q <= replay_cnt_q + 32'd1;
    end
  end

  assign perf_grant_o  = grant_cnt_q;
  assign perf_replay_o = replay_cnt_q;
`else
  assign perf_grant_o  = '0;
  assign perf_replay_o = '0;
`endif

`ifndef SYNTHESIS
  // Stale returns (e.g. after a mid-flight reset) are dropped; flag them for visibility.
  always_ff @(posedge clk_i) begin
    if (!rst_i && bus.mem_rtrn_vld_i) begin
      assert (rtrn_hit) else $warning("miss arb: return for non-pending id %0d dropped", bus.mem_rtrn_id_i);
    end
  end
`endif
endmodule

// File: tb/tb_wt_dcache_miss_arb.sv
// Directed bench for wt_dcache_miss_arb with 3 ports; expected values are hand-computed.
module tb_wt_dcache_miss_arb;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  pend_o;
  logic [31:0] perf_grant_o, perf_replay_o;
  int          nchecks = 0;
  int          nerrors = 0;

  always #5 clk_i = ~clk_i;

  wt_dcache_miss_arb_if #(.NumPorts(3), .PlenW(56), .IdW(2)) bus ();

  wt_dcache_miss_arb #(.NumPorts(3), .PlenW(56), .IdW(2), .ClOffW(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .bus           (bus),
    .pend_o        (pend_o),
    .perf_grant_o  (perf_grant_o),
    .perf_replay_o (perf_replay_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    bus.miss_req_i     = '0;
    bus.miss_paddr_i   = '0;
    bus.miss_nc_i      = '0;
    bus.miss_size_i    = '0;
    bus.mem_gnt_i      = 1'b0;
    bus.mem_rtrn_vld_i = 1'b0;
    bus.mem_rtrn_id_i  = '0;
  endtask

  task automatic set_req(input int p, input logic [55:0] addr);
    bus.miss_req_i[p]          = 1'b1;
    bus.miss_paddr_i[p*56+:56] = addr;
    bus.miss_size_i[p*3+:3]    = 3'b111;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    nchecks++; if (bus.mem_req_o !== 1'b0) begin nerrors++; $display("FAIL reset_mem_req: got %b exp 0", bus.mem_req_o); end
    nchecks++; if (pend_o !== 3'b000) begin nerrors++; $display("FAIL reset_pend: got %b exp 000", pend_o); end
    nchecks++; if (bus.miss_ack_o !== 3'b000) begin nerrors++; $display("FAIL reset_ack: got %b exp 000", bus.miss_ack_o); end
    nchecks++; if (bus.mem_paddr_o !== 56'h0) begin nerrors++; $display("FAIL reset_paddr: got %h exp 0", bus.mem_paddr_o); end
    nchecks++; if (perf_grant_o !== 32'h0) begin nerrors++; $display("FAIL reset_perf_grant: got %0d exp 0", perf_grant_o); end
    nchecks++; if (perf_replay_o !== 32'h0) begin nerrors++; $display("FAIL reset_perf_replay: got %0d exp 0", perf_replay_o); end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 56'h8000_0040);
    #1;
    nchecks++; if (bus.miss_ack_o !== 3'b001) begin nerrors++; $display("FAIL single_ack: got %b exp 001", bus.miss_ack_o); end
    tick();
    bus.miss_req_i = '0;
    #1;
    nchecks++; if (bus.mem_req_o !== 1'b1) begin nerrors++; $display("FAIL single_mem_req: got %b exp 1", bus.mem_req_o); end
    nchecks++; if (bus.mem_paddr_o !== 56'h8000_0040) begin nerrors++; $display("FAIL single_paddr: got %h exp 80000040", bus.mem_paddr_o); end
    nchecks++; if (bus.mem_id_o !== 2'd0) begin nerrors++; $display("FAIL single_id: got %0d exp 0", bus.mem_id_o); end
    nchecks++; if (bus.mem_size_o !== 3'b111) begin nerrors++; $display("FAIL single_size: got %b exp 111", bus.mem_size_o); end
    nchecks++; if (pend_o !== 3'b001) begin nerrors++; $display("FAIL single_pend: got %b exp 001", pend_o); end
    nchecks++; if (bus.miss_ack_o !== 3'b000) begin nerrors++; $display("FAIL single_no_ack_in_issue: got %b exp 000", bus.miss_ack_o); end
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
    #1;
    nchecks++; if (bus.mem_req_o !== 1'b0) begin nerrors++; $display("FAIL single_req_drop: got %b exp 0", bus.mem_req_o); end
    bus.mem_rtrn_vld_i = 1'b1;
    bus.mem_rtrn_id_i  = 2'd0;
    #1;
    nchecks++; if (bus.miss_rtrn_vld_o !== 3'b001) begin nerrors++; $display("FAIL single_rtrn: got %b exp 001", bus.miss_rtrn_vld_o); end
    tick();
    bus.mem_rtrn_vld_i = 1'b0;
    #1;
    nchecks++; if (pend_o !== 3'b000) begin nerrors++; $display("FAIL single_pend_clr: got %b exp 000", pend_o); end
  endtask

  // Requests stay high after their ack: pending ports must be ignored, not replayed.
  task automatic test_round_robin();
    logic [2:0] exp_ack [6];
    logic       exp_req [6];
    logic [1:0] exp_id  [6];
    exp_ack[0] = 3'b001; exp_ack[1] = 3'b000; exp_ack[2] = 3'b010;
    exp_ack[3] = 3'b000; exp_ack[4] = 3'b100; exp_ack[5] = 3'b000;
    exp_req[0] = 1'b0; exp_req[1] = 1'b1; exp_req[2] = 1'b0;
    exp_req[3] = 1'b1; exp_req[4] = 1'b0; exp_req[5] = 1'b1;
    exp_id[1] = 2'd0; exp_id[3] = 2'd1; exp_id[5] = 2'd2;
    exp_id[0] = 2'd0; exp_id[2] = 2'd0; exp_id[4] = 2'd1;
    do_reset();
    set_req(0, 56'h1000);
    set_req(1, 56'h2000);
    set_req(2, 56'h3000);
    bus.mem_gnt_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      nchecks++; if (bus.miss_ack_o !== exp_ack[i]) begin nerrors++; $display("FAIL rr_ack[%0d]: got %b exp %b", i, bus.miss_ack_o, exp_ack[i]); end
      nchecks++; if (bus.miss_replay_o !== 3'b000) begin nerrors++; $display("FAIL rr_replay[%0d]: got %b exp 000", i, bus.miss_replay_o); end
      nchecks++; if (bus.mem_req_o !== exp_req[i]) begin nerrors++; $display("FAIL rr_mem_req[%0d]: got %b exp %b", i, bus.mem_req_o, exp_req[i]); end
      nchecks++; if (bus.mem_id_o !== exp_id[i]) begin nerrors++; $display("FAIL rr_mem_id[%0d]: got %0d exp %0d", i, bus.mem_id_o, exp_id[i]); end
      tick();
    end
    bus.miss_req_i = '0;
    bus.mem_gnt_i  = 1'b0;
    for (int id = 0; id < 3; id++) begin
      bus.mem_rtrn_vld_i = 1'b1;
      bus.mem_rtrn_id_i  = 2'(id);
      tick();
    end
    bus.mem_rtrn_vld_i = 1'b0;
    #1;
    nchecks++; if (pend_o !== 3'b000) begin nerrors++; $display("FAIL rr_pend_clr: got %b exp 000", pend_o); end
    set_req(1, 56'h5000);
    set_req(0, 56'h4000);
    #1;
    nchecks++; if (bus.miss_ack_o !== 3'b001) begin nerrors++; $display("FAIL rr_wrap_ack0: got %b exp 001", bus.miss_ack_o); end
    tick();
    bus.miss_req_i[0] = 1'b0;
    bus.mem_gnt_i     = 1'b1;
    tick();
    bus.mem_gnt_i     = 1'b0;
    #1;
    nchecks++; if (bus.miss_ack_o !== 3'b010) begin nerrors++; $display("FAIL rr_wrap_ack1: got %b exp 010", bus.miss_ack_o); end
    tick();
    bus.miss_req_i = '0;
  endtask

  task automatic test_collision();
    do_reset();
    set_req(0, 56'h8000_0040);
    #1;
    nchecks++; if (bus.miss_ack_o !== 3'b001) begin nerrors++; $display("FAIL coll_ack0: got %b exp 001", bus.miss_ack_o); end
    tick();
    bus.miss_req_i = '0;
    bus.mem_gnt_i  = 1'b1;
    tick();
    bus.mem_gnt_i  = 1'b0;
    set_req(2, 56'h8000_0048);
    #1;
    nchecks++; if (bus.miss_replay_o !== 3'b100) begin nerrors++; $display("FAIL coll_replay: got %b exp 100", bus.miss_replay_o); end
    nchecks++; if (bus.miss_ack_o !== 3'b000) begin nerrors++; $display("FAIL coll_no_ack: got %b exp 000", bus.miss_ack_o); end
    tick();
    bus.mem_rtrn_vld_i = 1'b1;
    bus.mem_rtrn_id_i  = 2'd0;
    #1;
    nchecks++; if (bus.miss_rtrn_vld_o !== 3'b001) begin nerrors++; $display("FAIL coll_rtrn: got %b exp 001", bus.miss_rtrn_vld_o); end
    nchecks++; if (bus.miss_replay_o !== 3'b100) begin nerrors++; $display("FAIL coll_replay_on_clear: got %b exp 100", bus.miss_replay_o); end
    nchecks++; if (bus.miss_ack_o !== 3'b000) begin nerrors++; $display("FAIL coll_no_ack_on_clear: got %b exp 000", bus.miss_ack_o); end
    tick();
    bus.mem_rtrn_vld_i = 1'b0;
    #1;
    nchecks++; if (bus.miss_ack_o !== 3'b100) begin nerrors++; $display("FAIL coll_retry_ack: got %b exp 100", bus.miss_ack_o); end
    nchecks++; if (bus.miss_replay_o !== 3'b000) begin nerrors++; $display("FAIL coll_retry_no_replay: got %b exp 000", bus.miss_replay_o); end
    tick();
    bus.miss_req_i = '0;
    #1;
    nchecks++; if (pend_o !== 3'b100) begin nerrors++; $display("FAIL coll_pend: got %b exp 100", pend_o); end
    nchecks++; if (bus.mem_paddr_o !== 56'h8000_0048) begin nerrors++; $display("FAIL coll_paddr: got %h exp 80000048", bus.mem_paddr_o); end
    nchecks++; if (bus.mem_id_o !== 2'd2) begin nerrors++; $display("FAIL coll_id: got %0d exp 2", bus.mem_id_o); end
`ifdef WT_DCACHE_MISS_ARB_PERF_EN
    nchecks++; if (perf_grant_o !== 32'd2) begin nerrors++; $display("FAIL perf_grant: got %0d exp 2", perf_grant_o); end
    nchecks++; if (perf_replay_o !== 32'd2) begin nerrors++; $display("FAIL perf_replay: got %0d exp 2", perf_replay_o); end
`else
    nchecks++; if (perf_grant_o !== 32'd0) begin nerrors++; $display("FAIL perf_grant_off: got %0d exp 0", perf_grant_o); end
    nchecks++; if (perf_replay_o !== 32'd0) begin nerrors++; $display("FAIL perf_replay_off: got %0d exp 0", perf_replay_o); end
`endif
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
  endtask

  task automatic test_overlap();
    do_reset();
    set_req(1, 56'h100);
    #1;
    nchecks++; if (bus.miss_ack_o !== 3'b010) begin nerrors++; $display("FAIL ovl_ack1: got %b exp 010", bus.miss_ack_o); end
    tick();
    bus.miss_req_i = '0;
    bus.mem_gnt_i  = 1'b1;
    tick();
    bus.mem_gnt_i  = 1'b0;
    #1;
    nchecks++; if (pend_o !== 3'b010) begin nerrors++; $display("FAIL ovl_pend_before: got %b exp 010", pend_o); end
    set_req(2, 56'h200);
    bus.mem_rtrn_vld_i = 1'b1;
    bus.mem_rtrn_id_i  = 2'd1;
    #1;
    nchecks++; if (bus.miss_ack_o !== 3'b100) begin nerrors++; $display("FAIL ovl_ack2: got %b exp 100", bus.miss_ack_o); end
    nchecks++; if (bus.miss_rtrn_vld_o !== 3'b010) begin nerrors++; $display("FAIL ovl_rtrn: got %b exp 010", bus.miss_rtrn_vld_o); end
    tick();
    bus.miss_req_i     = '0;
    bus.mem_rtrn_vld_i = 1'b0;
    #1;
    nchecks++; if (pend_o !== 3'b100) begin nerrors++; $display("FAIL ovl_pend_after: got %b exp 100", pend_o); end
    bus.mem_gnt_i = 1'b1;
    tick();
    bus.mem_gnt_i = 1'b0;
  endtask

  task automatic test_reset_mid_issue();
    do_reset();
    set_req(0, 56'h8000_0040);
    tick();
    bus.miss_req_i = '0;
    #1;
    nchecks++; if (bus.mem_req_o !== 1'b1) begin nerrors++; $display("FAIL rmi_in_issue: got %b exp 1", bus.mem_req_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    nchecks++; if (bus.mem_req_o !== 1'b0) begin nerrors++; $display("FAIL rmi_mem_req: got %b exp 0", bus.mem_req_o); end
    nchecks++; if (pend_o !== 3'b000) begin nerrors++; $display("FAIL rmi_pend: got %b exp 000", pend_o); end
    bus.mem_rtrn_vld_i = 1'b1;
    bus.mem_rtrn_id_i  = 2'd0;
    #1;
    nchecks++; if (bus.miss_rtrn_vld_o !== 3'b000) begin nerrors++; $display("FAIL rmi_stale_rtrn: got %b exp 000", bus.miss_rtrn_vld_o); end
    tick();
    bus.mem_rtrn_vld_i = 1'b0;
    #1;
    nchecks++; if (pend_o !== 3'b000) begin nerrors++; $display("FAIL rmi_pend_after: got %b exp 000", pend_o); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_collision();
    test_overlap();
    test_reset_mid_issue();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
